// File: rtl/mpi_noc_out_arbiter.sv
// Packet-level round-robin arbiter sharing one registered NoC output link
// between N flit sources. A source that wins keeps the link until its
// last flit has been transferred, so packets never interleave.
//
// Handshake: a flit moves on input i when in_valid[i] & in_ready[i] at a
// rising clk edge, and on the output when out_valid & out_ready. Sources
// hold in_valid/in_flit/in_last stable until accepted. out_valid, out_flit
// and out_last are registered and stay stable while out_valid & !out_ready.
// The FSM state is visible through busy (1 = LOCKED, 0 = IDLE).
module mpi_noc_out_arbiter #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int N              = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic [N-1:0]                in_last,
    input  logic [N-1:0]                in_valid,
    output logic [N-1:0]                in_ready,
    output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                grant,
    output logic                        busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               ptr_q, ptr_d;
    logic [N-1:0]                grant_q, grant_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic [NOC_FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;

    logic                        load;
    logic                        win_found;
    logic [PW-1:0]               win_idx;
    logic [PW-1:0]               own_idx;
    logic [PW-1:0]               sel_idx;
    logic [NOC_FLIT_WIDTH-1:0]   sel_flit;
    logic                        sel_last;
    logic                        xfer;

    // Output register can take a new flit when empty or draining this cycle.
    assign load = !out_valid_q | out_ready;

    // Round-robin winner search starting just after the pointer, in wrap order.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!win_found && in_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // Index of the current lock owner, recovered from the one-hot grant.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                own_idx = PW'(i);
            end
        end
    end

    // Ready steering and flit/last selection for whichever source is served.
    always_comb begin
        in_ready = '0;
        sel_idx  = (state_q == LOCKED) ? own_idx : win_idx;
        sel_flit = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (state_q == LOCKED) begin
                in_ready[i] = grant_q[i] & load;
            end else if (win_found && (PW'(i) == win_idx)) begin
                in_ready[i] = load;
            end
            if (PW'(i) == sel_idx) begin
                sel_flit = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
                sel_last = in_last[i];
            end
        end
        xfer = |(in_valid & in_ready);
    end

    // Next-state logic: lock on a multi-flit packet, release on its last flit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_d = win_idx;
                    end else begin
                        state_d = LOCKED;
                        for (int i = 0; i < N; i++) begin
                            grant_d[i] = (PW'(i) == win_idx);
                        end
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = own_idx;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output register next value: capture on transfer, empty when drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_flit_d  = out_flit_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_flit_d  = sel_flit;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset gives source 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(N - 1);
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule
